ball_pos_ctrl: RTL
==================

Name: ball_pos_ctrl

Overview:
- Sequences sprite position updates from the BLE UART byte stream.
- Parses fixed-format position packets from the uart_rx byte output and range-checks and clamps the coordinates.
- Holds each accepted position in a pending buffer and commits it to the sprite ballx/bally inputs only on the new-frame strobe from video_sig_gen. This prevents mid-frame tearing.
- Sits between uart_rx and map_sprite_1 in the clk_pixel domain, replacing the switch-driven position.

Parameters:
- HEADER, 8'hA5, packet start byte.
- X_MAX, 159, maximum legal ballx; larger values are clamped to it.
- Y_MAX, 89, maximum legal bally; larger values are clamped to it.
- TIMEOUT_CYCLES, 742500, idle cycles allowed between bytes of one packet before it is abandoned (10 ms at 74.25 MHz).
- X_INIT, 80, ballx value after reset.
- Y_INIT, 45, bally value after reset.

Ports:
- clk_in, input, 1, pixel clock; all logic runs on its rising edge.
- rst_in, input, 1, synchronous active-high reset.
- byte_in, input, 8, received UART byte.
- byte_valid_in, input, 1, one-cycle pulse; byte_in is valid in that cycle.
- nf_in, input, 1, new-frame pulse from video_sig_gen.
- ballx_out, output, 8, committed sprite x position.
- bally_out, output, 7, committed sprite y position.
- pending_out, output, 1, high while an accepted position awaits commit.
- pkt_err_out, output, 1, one-cycle pulse on a timeout or a checksum failure.
- pkt_ok_count_out, output, 8, count of accepted packets; wraps 255 -> 0.

Behaviour:
- Synchronous active-high reset on clk_in. Reset values:
  - ballx_out = X_INIT, bally_out = Y_INIT.
  - pending_out = 0, pkt_err_out = 0, pkt_ok_count_out = 0.
  - FSM = IDLE, timeout counter = 0.
- Reset mid-packet discards all partial state. Reset has priority over every other event.
- Packet format: HEADER, X, Y, then SUM (SUM only when CHECKSUM_EN is defined).
- FSM states and transitions, evaluated only in cycles where byte_valid_in = 1:
  - IDLE: byte == HEADER -> GET_X. Any other byte is ignored silently (no error).
  - GET_X: latch X -> GET_Y.
  - GET_Y: latch Y. Without CHECKSUM_EN the packet completes -> IDLE. With CHECKSUM_EN -> GET_SUM.
  - GET_SUM: compare the byte to X ^ Y. Match: packet completes. Mismatch: pkt_err_out pulses. Either way -> IDLE.
  - No resynchronisation: a HEADER value received in GET_X, GET_Y or GET_SUM is treated as data.
- Timeout:
  - The counter runs in any state other than IDLE and clears on every byte_valid_in.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte: FSM -> IDLE, pkt_err_out pulses for 1 cycle, the partial packet is discarded.
  - If a byte arrives in the same cycle the count expires, the byte wins and no timeout occurs.
- Packet completion, in the cycle after the final byte's valid:
  - pend_x = min(X, X_MAX).
  - pend_y = min(Y, Y_MAX), truncated to 7 bits after clamping.
  - pending_out = 1 and pkt_ok_count_out increments.
  - A newer completed packet overwrites an uncommitted pending value (last-writer wins).
- Commit: on an nf_in cycle with pending_out = 1, ballx_out/bally_out take the pend values on the next edge and pending_out clears. nf_in with pending_out = 0 changes nothing.
- Packet completion and nf_in in the same cycle:
  - The commit uses the pend values registered before this cycle, if pending was set.
  - The new packet is written to pend and pending_out stays/becomes 1.
  - If pending was 0, no commit occurs this frame.
- Latency: last byte valid -> pending_out high is 1 cycle. nf_in -> outputs updated is 1 cycle.
- Outputs are registered and never glitch between commits.

Optional Feature:
- Macro name: CHECKSUM_EN.
- Defined: 4-byte packets. GET_SUM state is present. A mismatching SUM pulses pkt_err_out and leaves pend and the counter unchanged.
- Undefined: 3-byte packets. GET_SUM logic is not generated. pkt_err_out is asserted only by a timeout.

Test Plan:
- Reset, then nf_in pulses -> ballx_out = 80, bally_out = 45, pending_out = 0, pkt_ok_count_out = 0.
- Bytes A5, 30, 20 (plus SUM 10 when CHECKSUM_EN), then nf_in -> pending_out = 1 one cycle after the last byte; ballx_out = 0x30 and bally_out = 0x20 one cycle after nf_in; pkt_ok_count_out = 1.
- Bytes A5, C8, 7F (SUM B7 when CHECKSUM_EN) -> committed ballx_out = 159, bally_out = 89 (clamped).
- Bytes A5, 10, then no bytes for TIMEOUT_CYCLES -> one pkt_err_out pulse, outputs unchanged; a following valid packet A5, 05, 06 is accepted and commits 5/6.
- Two complete packets (1/2 then 3/4) before one nf_in -> commit 3/4, pkt_ok_count_out = 2. Last byte of a 7/8 packet coinciding with nf_in while 3/4 is pending -> outputs 3/4, pending_out = 1; the next nf_in commits 7/8.
- With CHECKSUM_EN: A5, 01, 02, 00 -> pkt_err_out pulse, no pending_out, count unchanged. Stray bytes 00, FF in IDLE -> no error and no state change.

Source files
------------

// File: rtl/ball_pos_ctrl_if.sv
// Byte-stream link from uart_rx into ball_pos_ctrl.
// Master drives the byte and its one-cycle valid pulse.
interface ball_pos_ctrl_if;
  logic [7:0] byte_in;
  logic       byte_valid_in;

  modport master (
    output byte_in,
    output byte_valid_in
  );

  modport slave (
    input byte_in,
    input byte_valid_in
  );
endinterface

// File: rtl/ball_pos_ctrl.sv
// Parses HEADER/X/Y[/SUM] packets and commits clamped positions on nf_in.
// Define CHECKSUM_EN for 4-byte packets with an X^Y checksum byte.
module ball_pos_ctrl #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned X_MAX          = 159,
  parameter int unsigned Y_MAX          = 89,
  parameter int unsigned TIMEOUT_CYCLES = 742500,
  parameter int unsigned X_INIT         = 80,
  parameter int unsigned Y_INIT         = 45
) (
  input  logic        clk_in,
  input  logic        rst_in,
  ball_pos_ctrl_if.slave bus,
  input  logic        nf_in,
  output logic [7:0]  ballx_out,
  output logic [6:0]  bally_out,
  output logic        pending_out,
  output logic        pkt_err_out,
  output logic [7:0]  pkt_ok_count_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [7:0] YM = 8'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE,
    GET_X,
    GET_Y,
    GET_SUM
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_x;
  logic [7:0]    r_px;
  logic [6:0]    r_py;
  logic          w_x_ld;
  logic          w_done;
  logic          w_err;
  logic [7:0]    w_fy;
  logic [7:0]    w_cx;
  logic [7:0]    w_cy;

`ifdef CHECKSUM_EN
  logic [7:0]    r_y;
  logic          w_y_ld;
  assign w_fy = r_y;
`else
  assign w_fy = bus.byte_in;
`endif

  assign w_cx = (r_x > XM) ? XM : r_x;
  assign w_cy = (w_fy > YM) ? YM : w_fy;

  always_comb begin
    w_state_nxt = r_state;
    w_x_ld      = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
`ifdef CHECKSUM_EN
    w_y_ld      = 1'b0;
`endif
    if (bus.byte_valid_in) begin
      unique case (r_state)
        IDLE: begin
          if (bus.byte_in == HEADER)
            w_state_nxt = GET_X;
        end
        GET_X: begin
          w_x_ld      = 1'b1;
          w_state_nxt = GET_Y;
        end
`ifdef CHECKSUM_EN
        GET_Y: begin
          w_y_ld      = 1'b1;
          w_state_nxt = GET_SUM;
        end
        GET_SUM: begin
          w_state_nxt = IDLE;
          if (bus.byte_in == (r_x ^ r_y))
            w_done = 1'b1;
          else
            w_err  = 1'b1;
        end
`else
        GET_Y: begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE && r_cnt == TO_LAST) begin
      // A byte in the expiry cycle takes the branch above instead
      w_state_nxt = IDLE;
      w_err       = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_x              <= '0;
`ifdef CHECKSUM_EN
      r_y              <= '0;
`endif
      r_px             <= '0;
      r_py             <= '0;
      ballx_out        <= 8'(X_INIT);
      bally_out        <= 7'(Y_INIT);
      pending_out      <= 1'b0;
      pkt_err_out      <= 1'b0;
      pkt_ok_count_out <= '0;
    end else begin
      r_state     <= w_state_nxt;
      pkt_err_out <= w_err;
      if (bus.byte_valid_in || w_state_nxt == IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (w_x_ld)
        r_x <= bus.byte_in;
`ifdef CHECKSUM_EN
      if (w_y_ld)
        r_y <= bus.byte_in;
`endif
      // Commit sees the pend values from before any same-cycle packet
      if (nf_in && pending_out) begin
        ballx_out <= r_px;
        bally_out <= r_py;
      end
      if (w_done) begin
        r_px             <= w_cx;
        r_py             <= w_cy[6:0];
        pending_out      <= 1'b1;
        pkt_ok_count_out <= pkt_ok_count_out + 8'd1;
      end else if (nf_in) begin
        pending_out <= 1'b0;
      end
    end
  end

endmodule
